// File: rtl/fft4_cmul_pkg.sv
// Shared types and constants for the FFT-4 complex-multiply sequencer.
// Holds the FSM state type, datapath widths and the product-order operand selector.
package fft4_cmul_pkg;

    localparam int unsigned MAG_W  = 8;
    localparam int unsigned SM_W   = 9;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned OUT_W  = 18;
    localparam int unsigned IDX_W  = 2;

    localparam logic [IDX_W-1:0] IDX_P0 = 2'd0;  // ar*br
    localparam logic [IDX_W-1:0] IDX_P1 = 2'd1;  // ai*bi
    localparam logic [IDX_W-1:0] IDX_P2 = 2'd2;  // ar*bi
    localparam logic [IDX_W-1:0] IDX_P3 = 2'd3;  // ai*br

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StDone
    } cmul_state_e;

    typedef struct packed {
        logic [SM_W-1:0] a;
        logic [SM_W-1:0] b;
    } op_pair_t;

    function automatic op_pair_t sel_ops(
        input logic [IDX_W-1:0] idx,
        input logic [SM_W-1:0]  ar,
        input logic [SM_W-1:0]  ai,
        input logic [SM_W-1:0]  br,
        input logic [SM_W-1:0]  bi
    );
        op_pair_t p;
        unique case (idx)
            IDX_P0:  begin p.a = ar; p.b = br; end
            IDX_P1:  begin p.a = ai; p.b = bi; end
            IDX_P2:  begin p.a = ar; p.b = bi; end
            default: begin p.a = ai; p.b = br; end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/fft4_cmul_seq_if.sv
// Operand/result handshakes plus the shared-multiplier bus of the FFT-4 sequencer.
// slave = sequencer side, master = environment (operand source, multiplier, sink).
interface fft4_cmul_seq_if;
    import fft4_cmul_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [SM_W-1:0]     ar;
    logic [SM_W-1:0]     ai;
    logic [SM_W-1:0]     br;
    logic [SM_W-1:0]     bi;

    logic                mul_en;
    logic [SM_W-1:0]     mul_a;
    logic [SM_W-1:0]     mul_b;
    logic [PROD_W:0]     mul_prdct;
    logic                mul_rdy;

    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_re;
    logic [OUT_W-1:0]    out_im;
    logic                err;

    modport slave (
        input  in_valid, ar, ai, br, bi, mul_prdct, mul_rdy, out_ready,
        output in_ready, mul_en, mul_a, mul_b, out_valid, out_re, out_im, err
    );

    modport master (
        output in_valid, ar, ai, br, bi, mul_prdct, mul_rdy, out_ready,
        input  in_ready, mul_en, mul_a, mul_b, out_valid, out_re, out_im, err
    );

endinterface

// File: rtl/fft4_sm_prod_sign.sv
// Applies the sign-magnitude operand signs to an unsigned multiplier magnitude,
// producing an 18-bit two's-complement product (negative zero folds to 0).
module fft4_sm_prod_sign
    import fft4_cmul_pkg::*;
(
    input  logic [PROD_W-1:0] mag_i,
    input  logic              sa_i,
    input  logic              sb_i,
    output logic [OUT_W-1:0]  prod_o
);

    logic [OUT_W-1:0] mag_ext;

    always_comb begin
        mag_ext = {{(OUT_W-PROD_W){1'b0}}, mag_i};
        prod_o  = (sa_i ^ sb_i) ? (~mag_ext + 1'b1) : mag_ext;
    end

endmodule

// File: rtl/fft4_cmul_seq.sv
// Sequences the four real products of a complex multiply through one shared multiplier
// and accumulates re = P0 - P1, im = P2 + P3. Optional watchdog: define CMUL_WDOG_EN.
module fft4_cmul_seq
    import fft4_cmul_pkg::*;
#(
    parameter int unsigned SKIP_RDY    = 1,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input logic              clk,
    input logic              rst_n,
    fft4_cmul_seq_if.slave   bus
);

    localparam int unsigned SKW = (SKIP_RDY > 0) ? $clog2(SKIP_RDY + 1) : 1;

    cmul_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SKW-1:0]     skip_q, skip_d;
    logic [SM_W-1:0]    ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic [OUT_W-1:0]   re_q, re_d, im_q, im_d;
    logic               in_ready_q, in_ready_d;

    op_pair_t           ops;
    logic [OUT_W-1:0]   prod;
    logic               accept;

`ifdef CMUL_WDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0]     wdog_q, wdog_d;
    logic               err_q, err_d;
`else
    logic               unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
`endif

    // Bit 16 of the multiplier result carries its own sign guess; sign is rebuilt locally.
    logic               unused_prdct_msb;
    assign unused_prdct_msb = bus.mul_prdct[PROD_W];

    assign ops = sel_ops(idx_q, ar_q, ai_q, br_q, bi_q);

    fft4_sm_prod_sign u_prod_sign (
        .mag_i  (bus.mul_prdct[PROD_W-1:0]),
        .sa_i   (ops.a[SM_W-1]),
        .sb_i   (ops.b[SM_W-1]),
        .prod_o (prod)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        br_d    = br_q;
        bi_d    = bi_q;
        re_d    = re_q;
        im_d    = im_q;
        accept  = 1'b0;
`ifdef CMUL_WDOG_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    ar_d    = bus.ar;
                    ai_d    = bus.ai;
                    br_d    = bus.br;
                    bi_d    = bus.bi;
                    idx_d   = IDX_P0;
                    re_d    = '0;
                    im_d    = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                skip_d  = SKW'(SKIP_RDY);
`ifdef CMUL_WDOG_EN
                wdog_d  = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                // The multiplier free-runs: the first SKIP_RDY pulses may carry the old product.
                if (bus.mul_rdy) begin
                    if (skip_q != '0) begin
                        skip_d = skip_q - 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                end
                if (accept) begin
                    unique case (idx_q)
                        IDX_P0:  re_d = re_q + prod;
                        IDX_P1:  re_d = re_q - prod;
                        IDX_P2:  im_d = im_q + prod;
                        default: im_d = im_q + prod;
                    endcase
                    if (idx_q == IDX_P3) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLoad;
                    end
                end
`ifdef CMUL_WDOG_EN
                else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
                    re_d    = '0;
                    im_d    = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
`endif
            end
            StDone: begin
                if (bus.out_ready) begin
`ifdef CMUL_WDOG_EN
                    err_d   = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so that in_ready stays low throughout reset and rises one clock later.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            skip_q     <= '0;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            re_q       <= '0;
            im_q       <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            skip_q     <= skip_d;
            ar_q       <= ar_d;
            ai_q       <= ai_d;
            br_q       <= br_d;
            bi_q       <= bi_d;
            re_q       <= re_d;
            im_q       <= im_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef CMUL_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.mul_en    = (state_q == StLoad) || (state_q == StWait);
        bus.mul_a     = bus.mul_en ? ops.a : '0;
        bus.mul_b     = bus.mul_en ? ops.b : '0;
        bus.out_valid = (state_q == StDone);
        bus.out_re    = (state_q == StDone) ? re_q : '0;
        bus.out_im    = (state_q == StDone) ? im_q : '0;
    end

endmodule

// File: tb/tb_fft4_cmul_seq.sv
// Self-checking bench for fft4_cmul_seq: free-running multiplier model with optional
// stale-pulse injection, and an integer reference for the complex product.
module tb_fft4_cmul_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fft4_cmul_seq_if bus ();

    fft4_cmul_seq #(
        .SKIP_RDY    (1),
        .WDOG_CYCLES (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Multiplier model controls
    int rdy_period = 3;
    bit inject     = 1'b0;
    bit mdl_off    = 1'b0;

    logic [8:0] prev_a, prev_b;
    bit         have_prev = 1'b0;
    bit         stale_next = 1'b0;
    int         cnt = 0;
    int         m;

    // Free-running multiplier: a correct pulse every rdy_period cycles after an operand
    // change; optionally a wrong-valued pulse on the first cycle after the change.
    always @(negedge clk) begin
        bus.mul_rdy   = 1'b0;
        bus.mul_prdct = '0;
        if (rst_n !== 1'b1 || bus.mul_en !== 1'b1 || mdl_off) begin
            have_prev  = 1'b0;
            stale_next = 1'b0;
            cnt        = 0;
        end else begin
            m = int'(bus.mul_a[7:0]) * int'(bus.mul_b[7:0]);
            if (!have_prev || bus.mul_a !== prev_a || bus.mul_b !== prev_b) begin
                prev_a     = bus.mul_a;
                prev_b     = bus.mul_b;
                have_prev  = 1'b1;
                stale_next = inject;
                cnt        = 0;
            end else begin
                cnt++;
                if (stale_next) begin
                    stale_next    = 1'b0;
                    bus.mul_rdy   = 1'b1;
                    bus.mul_prdct = {1'b0, ~m[15:0]};
                end else if (cnt % rdy_period == 0) begin
                    bus.mul_rdy   = 1'b1;
                    bus.mul_prdct = {1'($urandom_range(0, 1)), m[15:0]};
                end
            end
        end
    end

    function automatic int sm2int(input logic [8:0] v);
        return v[8] ? -int'(v[7:0]) : int'(v[7:0]);
    endfunction

    function automatic void ref_cmul(input logic [8:0] a_r, a_i, b_r, b_i,
                                     output logic [17:0] er, output logic [17:0] ei);
        int re, im;
        re = sm2int(a_r) * sm2int(b_r) - sm2int(a_i) * sm2int(b_i);
        im = sm2int(a_r) * sm2int(b_i) + sm2int(a_i) * sm2int(b_r);
        er = 18'(re);
        ei = 18'(im);
    endfunction

    task automatic start_txn(input logic [8:0] a_r, a_i, b_r, b_i, output bit to);
        int n = 0;
        to = 1'b0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            to = 1'b1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.ar = a_r;
        bus.ai = a_i;
        bus.br = b_r;
        bus.bi = b_i;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output bit to);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        to = (n >= limit);
    endtask

    task automatic run_txn(input logic [8:0] a_r, a_i, b_r, b_i, input int hold,
                           output logic [17:0] got_re, output logic [17:0] got_im,
                           output logic got_err, output bit to);
        start_txn(a_r, a_i, b_r, b_i, to);
        if (to) return;
        wait_valid(2000, to);
        if (to) return;
        got_re  = bus.out_re;
        got_im  = bus.out_im;
        got_err = bus.err;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.ar = '0;
        bus.ai = '0;
        bus.br = '0;
        bus.bi = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.mul_en, bus.err} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {bus.in_ready, bus.out_valid,
                     bus.mul_en, bus.err});
        end
        vectors++;
        if ({bus.out_re, bus.out_im, bus.mul_a, bus.mul_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: re %h im %h a %h b %h want 0", bus.out_re,
                     bus.out_im, bus.mul_a, bus.mul_b);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_rise: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic check_txn(input string name, input logic [8:0] a_r, a_i, b_r, b_i,
                             input int hold, input logic [17:0] er, input logic [17:0] ei);
        logic [17:0] r, i;
        logic e;
        bit to;
        run_txn(a_r, a_i, b_r, b_i, hold, r, i, e, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL %s_timeout: no handshake/result within bound", name);
            return;
        end
        if (r !== er || i !== ei || e !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got re %h im %h err %b want re %h im %h err 0", name, r, i, e,
                     er, ei);
        end
    endtask

    task automatic test_basic();
        rdy_period = 3;
        inject = 1'b0;
        check_txn("basic", 9'h003, 9'h002, 9'h004, 9'h105, 0, 18'd22, 18'h3FFF9);
    endtask

    task automatic test_extremes();
        rdy_period = 3;
        inject = 1'b0;
        check_txn("extreme_max", 9'h0FF, 9'h1FF, 9'h0FF, 9'h0FF, 0, 18'd130050, 18'd0);
        check_txn("neg_zero", 9'h100, 9'h100, 9'h100, 9'h100, 1, 18'd0, 18'd0);
    endtask

    task automatic test_stale();
        rdy_period = 3;
        inject = 1'b1;
        check_txn("stale_discard", 9'h003, 9'h002, 9'h004, 9'h105, 0, 18'd22, 18'h3FFF9);
        inject = 1'b0;
    endtask

    task automatic test_backpressure();
        bit to;
        rdy_period = 3;
        inject = 1'b0;
        start_txn(9'h003, 9'h002, 9'h004, 9'h105, to);
        if (!to) wait_valid(2000, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL bp_timeout: out_valid never rose");
            return;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_re !== 18'd22 || bus.out_im !== 18'h3FFF9 ||
                bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid %b re %h im %h rdy %b want 1 00016 3fff9 0",
                         k, bus.out_valid, bus.out_re, bus.out_im, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: valid %b in_ready %b want 0 1", bus.out_valid,
                     bus.in_ready);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_single_handshake: valid %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [8:0]  a_r, a_i, b_r, b_i;
        logic [17:0] er, ei;
        for (int t = 0; t < 25; t++) begin
            a_r = 9'($urandom_range(0, 511));
            a_i = 9'($urandom_range(0, 511));
            b_r = 9'($urandom_range(0, 511));
            b_i = 9'($urandom_range(0, 511));
            rdy_period = $urandom_range(2, 5);
            inject = 1'($urandom_range(0, 1));
            ref_cmul(a_r, a_i, b_r, b_i, er, ei);
            check_txn("random", a_r, a_i, b_r, b_i, $urandom_range(0, 3), er, ei);
        end
        inject = 1'b0;
        rdy_period = 3;
    endtask

    task automatic test_reset_midop();
        bit to;
        int n = 0;
        start_txn(9'h003, 9'h002, 9'h004, 9'h105, to);
        while (!(bus.mul_en === 1'b1 && bus.mul_a === 9'h003 && bus.mul_b === 9'h105) &&
               n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (to || n >= 200) begin
            miscompares++;
            $display("FAIL midop_reach_p2: product P2 operands never presented");
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.mul_en, bus.err, bus.out_re, bus.out_im,
             bus.mul_a, bus.mul_b} !== '0) begin
            miscompares++;
            $display("FAIL midop_reset_outputs: rdy %b val %b en %b err %b re %h im %h want 0",
                     bus.in_ready, bus.out_valid, bus.mul_en, bus.err, bus.out_re, bus.out_im);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_txn("after_reset", 9'h003, 9'h002, 9'h004, 9'h105, 0, 18'd22, 18'h3FFF9);
    endtask

    task automatic test_wdog();
        bit to;
        mdl_off = 1'b1;
        start_txn(9'h003, 9'h002, 9'h004, 9'h105, to);
        if (!to) wait_valid(200, to);
`ifdef CMUL_WDOG_EN
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL wdog_timeout: out_valid never rose");
        end else if (bus.err !== 1'b1 || bus.out_re !== '0 || bus.out_im !== '0) begin
            miscompares++;
            $display("FAIL wdog_abort: err %b re %h im %h want 1 0 0", bus.err, bus.out_re,
                     bus.out_im);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wdog_err_clear: err %b valid %b want 0 0", bus.err, bus.out_valid);
        end
`else
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL nowdog_stall: valid %b err %b want 0 0", bus.out_valid, bus.err);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        mdl_off = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_stale();
        test_backpressure();
        test_random();
        test_reset_midop();
        test_wdog();
        test_basic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/fft4_cmul_seq.md
Name: fft4_cmul_seq

Overview:
- Sequencer that sits around the FFT-4 radix stage's shared real multiplier (multiplier_4 instance).
- Accepts one complex operand pair per transaction, all operands in 9-bit sign-magnitude.
- Drives the four real products through the single multiplier, consuming only the 16-bit magnitude product and applying sign itself.
- Combines the products into an 18-bit two's-complement complex result for the butterfly adder.

Parameters:
- SKIP_RDY, 1, number of mul_rdy pulses discarded after each operand change; the multiplier free-runs, so a stale result can arrive first.
- WDOG_CYCLES, 64, watchdog limit per product; used only with CMUL_WDOG_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair (IDLE only)
- ar, ai, br, bi  in  9 each  sign-magnitude operands: bit8 = 1 means negative, bits[7:0] = magnitude
- mul_en  out  1  multiplier enable, high in LOAD/WAIT
- mul_a, mul_b  out  9 each  operands to the multiplier
- mul_prdct  in  17  multiplier result; only [15:0] is used, bit16 is ignored
- mul_rdy  in  1  multiplier result-ready pulse
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_re, out_im  out  18 each  two's-complement result
- err  out  1  watchdog abort flag; constant 0 without CMUL_WDOG_EN

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - All outputs 0, including in_ready (it rises on the first clock after release).
  - FSM goes to IDLE; product index, skip counter and accumulators are cleared.
  - Reset mid-transaction abandons the transaction. No output is produced.
- FSM states and transitions:
  - IDLE: in_ready = 1. in_valid & in_ready latches ar/ai/br/bi, sets idx = 0, goes to LOAD.
  - LOAD (1 cycle): mul_a/mul_b present the operands for idx; skip counter = SKIP_RDY; go to WAIT.
  - WAIT: each mul_rdy decrements the skip counter while it is nonzero (discarded). The first mul_rdy with counter = 0 is accepted.
  - On an accepted mul_rdy: capture the signed product, accumulate, then either idx++ and go to LOAD, or go to DONE if idx = 3.
  - DONE: out_valid = 1 and out_re/out_im are stable. out_valid & out_ready returns to IDLE. Outputs hold under backpressure.
- Product order:
  - P0 = ar*br
  - P1 = ai*bi
  - P2 = ar*bi
  - P3 = ai*br
- Arithmetic:
  - Product sign = sa XOR sb.
  - Signed product = magnitude (zero-extended to 18 bits), negated if the sign is 1. A negative zero gives 0.
  - re = P0 - P1, im = P2 + P3, computed in 18 bits. The range is ±130050, so no overflow is possible.
- mul_a/mul_b hold stable from LOAD through the end of WAIT. mul_rdy is ignored in IDLE, LOAD and DONE.
- Latency: 1 (accept) + 4 × (1 LOAD + cycles to the accepted rdy) + 1 to out_valid. The minimum is 10 cycles when each accepted rdy arrives on the first WAIT cycle with SKIP_RDY = 0.
- in_ready is low from LOAD through DONE; no second transaction can overlap.

Optional Feature:
- Macro: CMUL_WDOG_EN.
- Defined:
  - A WAIT cycle counter is reset on LOAD.
  - If it reaches WDOG_CYCLES without an accepted rdy, the FSM goes to DONE with out_re = out_im = 0 and err = 1.
  - err clears together with out_valid on the handshake.
- Undefined: no counter; err is tied to 0; WAIT may last indefinitely.

Decomposition:
- Package fft4_cmul_pkg holds:
  - state enum {IDLE, LOAD, WAIT, DONE};
  - MAG_W = 8, SM_W = 9, PROD_W = 16, OUT_W = 18;
  - product index constants.
- One sub-module, fft4_sm_prod_sign: combinational; takes the magnitude and two sign bits and produces the 18-bit signed product.
- The FSM and accumulators stay in the top module.

Test Plan:
- Basic signs: ar = 3, ai = 2, br = 4, bi = -5 (9'h105), multiplier model with rdy 3 cycles after an operand change, SKIP_RDY = 1 → out_re = 22, out_im = -7 (18'h3FFF9); err = 0.
- Extremes: ar = 255, ai = -255, br = 255, bi = 255 → out_re = 130050, out_im = 0. Also ar = ai = br = bi = -0 (9'h100) → re = im = 0.
- Stale-rdy discard: inject a mul_rdy on the first WAIT cycle of each product carrying a wrong product → it is ignored and the results match the basic case.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid, out_re and out_im remain stable and in_ready = 0. On release there is one handshake, then IDLE with in_ready = 1.
- Reset mid-op: drop rst_n during WAIT of P2 → all outputs are 0 immediately. The next transaction (basic values) gives 22 / -7.
- Watchdog (CMUL_WDOG_EN): never assert mul_rdy → after 64 WAIT cycles out_valid = 1, err = 1, re = im = 0. Without the macro, out_valid never rises.
